// File: rtl/my_pipelined_decoder_pkg.sv
// decoder_pkg: shared mode constants and handshake state encoding for the decoder stage
package decoder_pkg;
    localparam logic DEC_ONEHOT = 1'b0;
    localparam logic DEC_THERMO = 1'b1;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;
endpackage

// File: rtl/my_decode_word.sv
// my_decode_word: combinational one-hot / thermometer decode with enable gate and optional zeroed bit 0
module my_decode_word
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter int MASK_ZERO = 1
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  enable,
    input  logic                  mode,
    output logic [2**SEL_W-1:0]   bits
);
    localparam int OUT_W = 2**SEL_W;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] thermo;
    logic [OUT_W-1:0] word;
    always_comb begin
        onehot = OUT_W'(1) << sel;
        thermo = (onehot << 1) - OUT_W'(1);
        word   = enable ? ((mode == DEC_THERMO) ? thermo : onehot) : '0;
        bits   = (MASK_ZERO != 0) ? (word & ~OUT_W'(1)) : word;
    end
endmodule

// File: rtl/my_pipelined_decoder.sv
// my_pipelined_decoder: registered decoder stage with two-entry skid buffer, valid/ready handshake and flush
module my_pipelined_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter int MASK_ZERO = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_enable,
    input  logic                in_mode,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2**SEL_W-1:0] out_bits,
    output logic [SEL_W-1:0]    out_sel
);
    localparam int OUT_W = 2**SEL_W;
    state_t           state_q, state_d;
    logic [OUT_W-1:0] or_bits_q, or_bits_d, sk_bits_q, sk_bits_d, dec_bits;
    logic [SEL_W-1:0] or_sel_q, or_sel_d, sk_sel_q, sk_sel_d;
    logic             in_ready_q, in_ready_d;
    logic             in_xfer, out_xfer;
    my_decode_word #(.SEL_W(SEL_W), .MASK_ZERO(MASK_ZERO)) u_dec (
        .sel    (in_sel),
        .enable (in_enable),
        .mode   (in_mode),
        .bits   (dec_bits)
    );
    assign in_ready  = in_ready_q;
    assign out_valid = state_q != ST_EMPTY;
    assign out_bits  = or_bits_q;
    assign out_sel   = or_sel_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;
    always_comb begin
        state_d   = state_q;
        or_bits_d = or_bits_q;
        or_sel_d  = or_sel_q;
        sk_bits_d = sk_bits_q;
        sk_sel_d  = sk_sel_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) begin
                    state_d   = ST_ONE;
                    or_bits_d = dec_bits;
                    or_sel_d  = in_sel;
                end
                ST_ONE: if (in_xfer && out_xfer) begin
                    or_bits_d = dec_bits;
                    or_sel_d  = in_sel;
                end else if (in_xfer) begin
                    state_d   = ST_TWO;
                    sk_bits_d = dec_bits;
                    sk_sel_d  = in_sel;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
                ST_TWO: if (out_xfer) begin
                    state_d   = ST_ONE;
                    or_bits_d = sk_bits_q;
                    or_sel_d  = sk_sel_q;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = state_d != ST_TWO;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            or_bits_q  <= '0;
            or_sel_q   <= '0;
            sk_bits_q  <= '0;
            sk_sel_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            or_bits_q  <= or_bits_d;
            or_sel_q   <= or_sel_d;
            sk_bits_q  <= sk_bits_d;
            sk_sel_q   <= sk_sel_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_my_pipelined_decoder.sv
// tb_my_pipelined_decoder: directed checks of decode, handshake, back-pressure, flush and reset, plus a scoreboard phase
module tb_my_pipelined_decoder;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_enable, in_mode, flush, out_ready;
    logic [4:0]  in_sel;
    logic        rdy1, vld1, rdy0, vld0;
    logic [31:0] bits1, bits0;
    logic [4:0]  sel1, sel0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] q[$];
    always #5 clock = ~clock;
    my_pipelined_decoder #(.SEL_W(5), .MASK_ZERO(1)) d1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_sel(in_sel), .in_enable(in_enable), .in_mode(in_mode), .flush(flush),
        .out_valid(vld1), .out_ready(out_ready), .out_bits(bits1), .out_sel(sel1)
    );
    my_pipelined_decoder #(.SEL_W(5), .MASK_ZERO(0)) d0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_sel(in_sel), .in_enable(in_enable), .in_mode(in_mode), .flush(flush),
        .out_valid(vld0), .out_ready(out_ready), .out_bits(bits0), .out_sel(sel0)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    function automatic logic [31:0] exp_oh(input logic [4:0] s, input logic en);
        logic [31:0] w;
        w = 32'd1 << s;
        return en ? (w & 32'hFFFF_FFFE) : 32'd0;
    endfunction
    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_enable = 1'b1;
        in_mode = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_valid", vld1, 0);
        chk("rst_ready", rdy1, 1);
        chk("rst_bits", bits1, 0);
        chk("rst_sel", sel1, 0);
        reset_n = 1'b1;
        in_valid = 1'b1; in_sel = 5'd0; step();
        chk("oh0_valid", vld1, 1);
        chk("oh0_bits_m1", bits1, 32'h0000_0000);
        chk("oh0_bits_m0", bits0, 32'h0000_0001);
        in_sel = 5'd1; step();
        chk("oh1_bits", bits1, 32'h0000_0002);
        chk("oh1_sel", sel1, 5'd1);
        in_sel = 5'd5; step();
        chk("oh5_bits", bits1, 32'h0000_0020);
        in_sel = 5'd31; step();
        chk("oh31_bits", bits1, 32'h8000_0000);
        chk("oh31_sel", sel1, 5'd31);
        in_mode = 1'b1; in_sel = 5'd3; step();
        chk("th3_m0", bits0, 32'h0000_000F);
        chk("th3_m1", bits1, 32'h0000_000E);
        in_enable = 1'b0; in_sel = 5'd31; step();
        chk("th31_dis_bits", bits0, 32'h0000_0000);
        chk("th31_dis_valid", vld0, 1);
        in_enable = 1'b1; step();
        chk("th31_m0", bits0, 32'hFFFF_FFFF);
        chk("th31_m1", bits1, 32'hFFFF_FFFE);
        in_valid = 1'b0; step();
        chk("idle_valid", vld0, 0);
        chk("idle_hold", bits0, 32'hFFFF_FFFF);
        in_mode = 1'b0; in_valid = 1'b1; in_sel = 5'd1; step();
        out_ready = 1'b0; in_sel = 5'd2; step();
        chk("bp_ready_fall", rdy1, 0);
        chk("bp_bits0", bits1, 32'h2);
        in_sel = 5'd3; step(); step();
        chk("bp_ready_low", rdy1, 0);
        chk("bp_bits_hold", bits1, 32'h2);
        chk("bp_valid", vld1, 1);
        out_ready = 1'b1; step();
        chk("bp_drain1", bits1, 32'h4);
        chk("bp_ready_rise", rdy1, 1);
        step();
        chk("bp_drain2", bits1, 32'h8);
        chk("bp_drain2_valid", vld1, 1);
        in_valid = 1'b0; step();
        chk("bp_empty", vld1, 0);
        in_valid = 1'b1; out_ready = 1'b0; in_sel = 5'd4; step();
        in_sel = 5'd6; step();
        chk("fl_two", rdy1, 0);
        flush = 1'b1; in_sel = 5'd7; step();
        chk("fl_valid", vld1, 0);
        chk("fl_ready", rdy1, 1);
        chk("fl_hold", bits1, 32'h10);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk("fl_stay_empty", vld1, 0);
        in_valid = 1'b1; in_sel = 5'd9; step();
        chk("fl_next_word", bits1, 32'h200);
        in_sel = 5'd3; step();
        chk("mid_bits", bits1, 32'h8);
        reset_n = 1'b0; #1;
        chk("arst_valid", vld1, 0);
        chk("arst_ready", rdy1, 1);
        chk("arst_bits", bits1, 0);
        step();
        reset_n = 1'b1; in_sel = 5'd2; step();
        chk("post_rst_valid", vld1, 1);
        chk("post_rst_bits", bits1, 32'h4);
        in_valid = 1'b0; step();
        q.delete();
        for (int i = 0; i < 3000; i++) begin
            logic ix, ox;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sel    = 5'($urandom_range(0, 31));
            in_enable = ($urandom_range(0, 7) != 0);
            #1;
            chk("rnd_valid", vld1, q.size() != 0);
            chk("rnd_ready", rdy1, q.size() < 2);
            if (q.size() != 0) chk("rnd_bits", bits1, q[0]);
            ix = in_valid && (q.size() < 2);
            ox = out_ready && (q.size() != 0);
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(exp_oh(in_sel, in_enable));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
